// File: rtl/bram_arbiter_if.sv
// Requester-side bundle for one port of the shared BRAM arbiter.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready may depend combinationally on
// req_valid. While req_valid is high without req_ready, the requester
// holds req_we/req_addr/req_wdata stable. rsp_valid is a one-cycle strobe
// that cannot be back-pressured. rsp_rdata is meaningful only while
// rsp_valid is high and otherwise holds its last value.
interface bram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port BRAM
// (1-cycle read latency, read-first). Every accepted request produces a
// response LATENCY cycles after its accept edge on the requesting port.
// Optionally zero-fills the whole BRAM after reset before serving requests.
// LATENCY must lie in 2..32.
module bram_arbiter #(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 32,
   parameter int LATENCY        = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   bram_arbiter_if.slave     m0,
   bram_arbiter_if.slave     m1,
   output logic              o_bram_en,
   output logic              o_bram_we,
   output logic [ADDR_W-1:0] o_bram_a,
   output logic [DATA_W-1:0] o_bram_di,
   input  logic [DATA_W-1:0] i_bram_do,
   output logic              o_init_done,
   output logic              o_dbg_state
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_clearing;
   logic [ADDR_W-1:0] r_clr_addr;

   logic              r_rr;        // 0: M0 wins a tie, 1: M1 wins a tie
   logic              w_run;
   logic              w_both;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc;

   // Tag line: bit i is the tag of the access accepted i+1 edges ago.
   logic [LATENCY-1:0] r_tag_v;
   logic [LATENCY-1:0] r_tag_p;    // 1 = response belongs to M1
   logic [DATA_W-1:0]  w_rsp_data; // read data aligned with r_tag[LATENCY-1]

   logic              r_rsp_v0;
   logic              r_rsp_v1;
   logic [DATA_W-1:0] r_rsp_d0;
   logic [DATA_W-1:0] r_rsp_d1;

   // State register: reset lands in CLEAR only when the fill is enabled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: leave CLEAR on the edge that issues the last fill word.
   always_comb begin
      w_state_nxt = r_state;
      w_clearing  = 1'b0;
      if (r_state == ST_CLEAR) begin
         w_clearing = 1'b1;
         if (r_clr_addr == '1) begin
            w_state_nxt = ST_RUN;
         end
      end
   end

   // Fill address walks 0..DEPTH-1, one word per cycle while clearing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clr_addr <= '0;
      end else if (w_clearing) begin
         r_clr_addr <= r_clr_addr + 1'b1;
      end
   end

   assign o_init_done = (r_state == ST_RUN);
   assign o_dbg_state = r_state;

   // Grants are combinational; nobody is served while clearing or in reset.
   assign w_run  = (r_state == ST_RUN) && !i_rst;
   assign w_both = m0.req_valid && m1.req_valid;
   assign w_gnt0 = w_run && m0.req_valid && (!m1.req_valid || !r_rr);
   assign w_gnt1 = w_run && m1.req_valid && (!m0.req_valid ||  r_rr);
   assign w_acc  = w_gnt0 || w_gnt1;

   assign m0.req_ready = w_gnt0;
   assign m1.req_ready = w_gnt1;

   // Round-robin pointer moves to the loser only after a contested accept.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr <= 1'b0;
      end else if (w_run && w_both) begin
         r_rr <= ~r_rr;
      end
   end

   // BRAM command register: fill write, winner's access, or idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_bram_en <= 1'b0;
         o_bram_we <= 1'b0;
         o_bram_a  <= '0;
         o_bram_di <= '0;
      end else if (w_clearing) begin
         o_bram_en <= 1'b1;
         o_bram_we <= 1'b1;
         o_bram_a  <= r_clr_addr;
         o_bram_di <= '0;
      end else if (w_gnt0) begin
         o_bram_en <= 1'b1;
         o_bram_we <= m0.req_we;
         o_bram_a  <= m0.req_addr;
         o_bram_di <= m0.req_wdata;
      end else if (w_gnt1) begin
         o_bram_en <= 1'b1;
         o_bram_we <= m1.req_we;
         o_bram_a  <= m1.req_addr;
         o_bram_di <= m1.req_wdata;
      end else begin
         o_bram_en <= 1'b0;
         o_bram_we <= 1'b0;
      end
   end

   // Tag shift line; reset drops every access still in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tag_v <= '0;
         r_tag_p <= '0;
      end else begin
         r_tag_v <= {r_tag_v[LATENCY-2:0], w_acc};
         r_tag_p <= {r_tag_p[LATENCY-2:0], w_gnt1};
      end
   end

   // Read data is captured two edges after accept and delayed to match the tag.
   generate
      if (LATENCY == 2) begin : g_dpipe_none
         assign w_rsp_data = i_bram_do;
      end else begin : g_dpipe
         logic [DATA_W-1:0] r_dpipe [LATENCY-2];

         // Data delay line; stage 0 samples BRAM Do.
         always_ff @(posedge i_clk) begin
            r_dpipe[0] <= i_bram_do;
            for (int i = 1; i < LATENCY - 2; i++) begin
               r_dpipe[i] <= r_dpipe[i-1];
            end
         end

         assign w_rsp_data = r_dpipe[LATENCY-3];
      end
   endgenerate

   // Response registers: strobe the tagged port, hold data between strobes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_v0 <= 1'b0;
         r_rsp_v1 <= 1'b0;
         r_rsp_d0 <= '0;
         r_rsp_d1 <= '0;
      end else begin
         r_rsp_v0 <= r_tag_v[LATENCY-1] && !r_tag_p[LATENCY-1];
         r_rsp_v1 <= r_tag_v[LATENCY-1] &&  r_tag_p[LATENCY-1];
         if (r_tag_v[LATENCY-1] && !r_tag_p[LATENCY-1]) begin
            r_rsp_d0 <= w_rsp_data;
         end
         if (r_tag_v[LATENCY-1] && r_tag_p[LATENCY-1]) begin
            r_rsp_d1 <= w_rsp_data;
         end
      end
   end

   assign m0.rsp_valid = r_rsp_v0;
   assign m0.rsp_rdata = r_rsp_d0;
   assign m1.rsp_valid = r_rsp_v1;
   assign m1.rsp_rdata = r_rsp_d1;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a behavioural BRAM on the memory pins, and a
// reference model that tracks memory contents, clear progress, tie-break
// order and a queue of expected responses keyed by due cycle.
module tb_bram_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int LAT    = 10;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int EW     = 32 + 1 + DATA_W;   // {due cycle, port, data}

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_a;
   logic [DATA_W-1:0] bram_di;
   logic [DATA_W-1:0] bram_do;
   logic              init_done;
   logic              dbg_state;

   bram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .i_clk(clk), .i_rst(rst), .m0(m0_if), .m1(m1_if),
      .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_a(bram_a),
      .o_bram_di(bram_di), .i_bram_do(bram_do),
      .o_init_done(init_done), .o_dbg_state(dbg_state)
   );

   // Behavioural single-port read-first BRAM with 1-cycle Do.
   logic [DATA_W-1:0] bram_mem [DEPTH];
   always @(posedge clk) begin
      if (bram_en) begin
         bram_do <= bram_mem[bram_a];
         if (bram_we) bram_mem[bram_a] = bram_di;
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [EW-1:0]     exp_q [$];
   logic              m_run;
   logic              m_rr;
   int                m_cnt;
   int                cyc;
   logic              m_acc0, m_acc1;
   logic              d_rdy0, d_rdy1;
   logic [DATA_W-1:0] m_last0, m_last1;
   int                n_total;
   int                n_bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: check grants, advance the model on the edge, check outputs.
   task automatic tick();
      logic              e0, e1, clr, p, we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int                clr_a;
      logic              ev0, ev1;
      logic [DATA_W-1:0] ed;
      logic [EW-1:0]     ent;
      logic              both;
      #1;
      e0 = m_run && !rst && m0_if.req_valid && (!m1_if.req_valid || !m_rr);
      e1 = m_run && !rst && m1_if.req_valid && (!m0_if.req_valid ||  m_rr);
      check("m0_ready", m0_if.req_ready, e0);
      check("m1_ready", m1_if.req_ready, e1);
      d_rdy0 = m0_if.req_ready;
      d_rdy1 = m1_if.req_ready;
      m_acc0 = e0;
      m_acc1 = e1;
      clr    = !rst && !m_run;
      clr_a  = m_cnt;
      both   = m0_if.req_valid && m1_if.req_valid;
      p  = e1;
      we = e1 ? m1_if.req_we    : m0_if.req_we;
      a  = e1 ? m1_if.req_addr  : m0_if.req_addr;
      d  = e1 ? m1_if.req_wdata : m0_if.req_wdata;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_run = 1'b0;
         m_cnt = 0;
         m_rr  = 1'b0;
         m_last0 = '0;
         m_last1 = '0;
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
         if (e0 || e1) begin
            exp_q.push_back({32'(cyc + LAT), p, ref_mem[a]});
            if (we) ref_mem[a] = d;
         end
         if (m_run && both) m_rr = !m_rr;
         if (!m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1'b1;
         end
      end
      @(negedge clk);
      check("bram_en", bram_en, e0 || e1 || clr);
      if (clr) begin
         check("clr_we", bram_we, 1'b1);
         check("clr_a", bram_a, clr_a[ADDR_W-1:0]);
         check("clr_di", bram_di, '0);
      end else if (e0 || e1) begin
         check("bram_we", bram_we, we);
         check("bram_a", bram_a, a);
         if (we) check("bram_di", bram_di, d);
      end
      check("init_done", init_done, m_run);
      check("dbg_state", dbg_state, m_run);
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = '0;
      if (exp_q.size() > 0) begin
         ent = exp_q[0];
         if (int'(ent[EW-1 -: 32]) == cyc) begin
            void'(exp_q.pop_front());
            ed  = ent[DATA_W-1:0];
            ev0 = !ent[DATA_W];
            ev1 =  ent[DATA_W];
         end
      end
      if (ev0) m_last0 = ed;
      if (ev1) m_last1 = ed;
      check("m0_rsp_valid", m0_if.rsp_valid, ev0);
      check("m1_rsp_valid", m1_if.rsp_valid, ev1);
      check("m0_rsp_rdata", m0_if.rsp_rdata, m_last0);
      check("m1_rsp_rdata", m1_if.rsp_rdata, m_last1);
   endtask

   task automatic idle(input int n);
      m0_if.req_valid = 1'b0;
      m1_if.req_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Single-cycle request from one port; the other port stays idle.
   task automatic req_one(input logic p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      m0_if.req_valid = !p;
      m1_if.req_valid =  p;
      if (p) begin
         m1_if.req_we = we; m1_if.req_addr = a; m1_if.req_wdata = d;
      end else begin
         m0_if.req_we = we; m0_if.req_addr = a; m0_if.req_wdata = d;
      end
      tick();
      m0_if.req_valid = 1'b0;
      m1_if.req_valid = 1'b0;
   endtask

   // Release reset and wait for the clear to finish, measuring its length.
   task automatic wait_init();
      int n;
      rst = 1'b0;
      n = 0;
      while (!init_done && n < DEPTH + 8) begin
         tick();
         n++;
      end
      check("init_lat", n, DEPTH);
   endtask

   initial begin
      int g0, g1;
      n_total = 0; n_bad = 0; cyc = 0;
      m_run = 1'b0; m_rr = 1'b0; m_cnt = 0;
      m_last0 = '0; m_last1 = '0;
      for (int i = 0; i < DEPTH; i++) bram_mem[i] = $urandom;
      rst = 1'b1;
      m0_if.req_valid = 1'b0; m0_if.req_we = 1'b0; m0_if.req_addr = '0; m0_if.req_wdata = '0;
      m1_if.req_valid = 1'b0; m1_if.req_we = 1'b0; m1_if.req_addr = '0; m1_if.req_wdata = '0;

      // Reset and the initial zero-fill
      repeat (3) tick();
      wait_init();

      // Fill must have zeroed both ends of the array
      for (int i = 0; i < 32; i++) begin
         req_one(i[0], 1'b0, (i < 16) ? ADDR_W'(i) : ADDR_W'('h1FF0 + i - 16), '0);
      end
      idle(LAT + 2);

      // Write then read-back on consecutive edges
      req_one(1'b0, 1'b1, ADDR_W'('h005), 32'hDEADBEEF);
      req_one(1'b0, 1'b0, ADDR_W'('h005), '0);
      idle(LAT + 2);

      // Both ports contend for 6 cycles: grants must alternate
      g0 = 0; g1 = 0;
      m0_if.req_valid = 1'b1; m0_if.req_we = 1'b1; m0_if.req_addr = ADDR_W'('h100);
      m0_if.req_wdata = $urandom;
      m1_if.req_valid = 1'b1; m1_if.req_we = 1'b0; m1_if.req_addr = ADDR_W'('h005);
      m1_if.req_wdata = '0;
      for (int c = 0; c < 6; c++) begin
         tick();
         g0 += int'(d_rdy0);
         g1 += int'(d_rdy1);
         if (m_acc0) begin
            m0_if.req_addr = m0_if.req_addr + 1'b1;
            m0_if.req_wdata = $urandom;
         end
         if (m_acc1) m1_if.req_addr = m1_if.req_addr + ADDR_W'('h0FB);
      end
      check("both_m0_grants", g0, 3);
      check("both_m1_grants", g1, 3);
      idle(LAT + 2);

      // M1 alone at the top and bottom of the address space
      req_one(1'b1, 1'b0, ADDR_W'('h1FFF), '0);
      req_one(1'b1, 1'b0, ADDR_W'('h0000), '0);
      idle(LAT + 2);

      // Random traffic on a small address window with held requests
      for (int c = 0; c < 400; c++) begin
         if (!m0_if.req_valid && $urandom_range(0, 9) < 7) begin
            m0_if.req_valid = 1'b1;
            m0_if.req_we    = $urandom_range(0, 1) == 1;
            m0_if.req_addr  = ADDR_W'($urandom_range(0, 15));
            m0_if.req_wdata = $urandom;
         end
         if (!m1_if.req_valid && $urandom_range(0, 9) < 6) begin
            m1_if.req_valid = 1'b1;
            m1_if.req_we    = $urandom_range(0, 1) == 1;
            m1_if.req_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'('h1FFF)
                                                           : ADDR_W'($urandom_range(0, 15));
            m1_if.req_wdata = $urandom;
         end
         tick();
         if (m_acc0) m0_if.req_valid = 1'b0;
         if (m_acc1) m1_if.req_valid = 1'b0;
      end
      idle(LAT + 2);

      // Reset with four reads in flight, M0 request held through the clear
      req_one(1'b0, 1'b0, ADDR_W'(1), '0);
      req_one(1'b1, 1'b0, ADDR_W'(2), '0);
      req_one(1'b0, 1'b0, ADDR_W'(3), '0);
      req_one(1'b1, 1'b0, ADDR_W'(4), '0);
      rst = 1'b1;
      m0_if.req_valid = 1'b1; m0_if.req_we = 1'b0; m0_if.req_addr = ADDR_W'(7);
      repeat (2) tick();
      wait_init();
      tick();
      check("held_accept", m_acc0, 1'b1);
      m0_if.req_valid = 1'b0;

      // Contents zero again after the second fill
      for (int i = 0; i < 16; i++) req_one(i[1], 1'b0, ADDR_W'(i), '0);
      req_one(1'b1, 1'b0, ADDR_W'('h1FFF), '0);
      idle(LAT + 2);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
